// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared state encoding and mode/transfer constants for the DMA timing engine
package dma_pkg;

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        S4 = 3'd5
    } dmaState_t;

    localparam logic [1:0] XFER_VERIFY = 2'b00;
    localparam logic [1:0] XFER_WRITE  = 2'b01;
    localparam logic [1:0] XFER_READ   = 2'b10;

    localparam logic [1:0] MODE_DEMAND = 2'b00;
    localparam logic [1:0] MODE_SINGLE = 2'b01;
    localparam logic [1:0] MODE_BLOCK  = 2'b10;

endpackage

// File: rtl/dma_priority_resolver.sv
// rtl/dma_priority_resolver.sv - combinational fixed/rotating priority pick among four DREQ lines
module dma_priority_resolver (
    input  logic [3:0] DREQ,
    input  logic [1:0] rotPtr,
    input  logic       cmdRotate,
    output logic       grantValid,
    output logic [1:0] grantIdx
);

    logic [1:0] base;
    logic [7:0] doubled;
    logic [3:0] rotated;
    logic [1:0] offset;

    // Rotate requests so the highest-priority channel lands at bit 0, pick lowest set bit, rotate back.
    always_comb begin
        base    = cmdRotate ? rotPtr : 2'd0;
        doubled = {DREQ, DREQ} >> base;
        rotated = doubled[3:0];
        if (rotated[0])      offset = 2'd0;
        else if (rotated[1]) offset = 2'd1;
        else if (rotated[2]) offset = 2'd2;
        else                 offset = 2'd3;
        grantValid = |DREQ;
        grantIdx   = base + offset;
    end

endmodule

// File: rtl/dma_timing_control.sv
// rtl/dma_timing_control.sv - DMA request arbitration, HRQ/HLDA handshake and S0-S4 transfer sequencing
module dma_timing_control
    import dma_pkg::*;
(
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] DREQ,
    input  logic       HLDA,
    input  logic       EOP_N_IN,
    input  logic       cmdDisable,
    input  logic       cmdRotate,
    input  logic [7:0] modeXfer,
    input  logic [7:0] modeSel,
    input  logic       tcIn,
    output logic       HRQ,
    output logic [3:0] DACK,
    output logic       AEN,
    output logic       ADSTB,
    output logic       MEMR_N,
    output logic       MEMW_N,
    output logic       IOR_N_OUT,
    output logic       IOW_N_OUT,
    output logic       EOP_N_OUT,
    output logic [1:0] activeChannel,
    output logic       programCondition,
    output logic       loadAddr,
    output logic       updateCurrentAddressReg,
    output logic       updateCurrentWordCountReg,
    output logic       intEOP
);

    dmaState_t  state, nextState;
    logic [1:0] rotPtr;
    logic       eopLatch;
    logic       grantValid;
    logic [1:0] grantIdx;
    logic       chReq;
    logic [1:0] chXfer;
    logic [1:0] chMode;
    logic       inXfer;
    logic       terminate;

    dma_priority_resolver u_resolver (
        .DREQ       (DREQ),
        .rotPtr     (rotPtr),
        .cmdRotate  (cmdRotate),
        .grantValid (grantValid),
        .grantIdx   (grantIdx)
    );

    always_comb begin
        chReq     = DREQ[activeChannel];
        chXfer    = modeXfer[{activeChannel, 1'b0} +: 2];
        chMode    = modeSel[{activeChannel, 1'b0} +: 2];
        inXfer    = (state == S1) || (state == S2) || (state == S3) || (state == S4);
        terminate = tcIn || eopLatch;
    end

    always_comb begin
        nextState = state;
        case (state)
            SI: if (!cmdDisable && grantValid) nextState = S0;
            S0: begin
                if (!chReq)     nextState = SI;
                else if (HLDA)  nextState = S1;
            end
            S1: nextState = HLDA ? S2 : SI;
            S2: nextState = HLDA ? S3 : SI;
            S3: nextState = HLDA ? S4 : SI;
            S4: begin
                if (!HLDA || terminate) nextState = SI;
                else if (chMode == MODE_BLOCK) nextState = S1;
                else if (chMode == MODE_DEMAND) nextState = chReq ? S1 : SI;
                else nextState = SI;
            end
            default: nextState = SI;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state         <= SI;
            activeChannel <= 2'd0;
            rotPtr        <= 2'd0;
            eopLatch      <= 1'b0;
        end else begin
            state <= nextState;
            if (state == SI && nextState == S0)
                activeChannel <= grantIdx;
            // Serviced channel drops to lowest priority once its transfer completes normally.
            if (state == S4 && HLDA)
                rotPtr <= activeChannel + 2'd1;
            if (inXfer && HLDA && state != S4)
                eopLatch <= eopLatch || !EOP_N_IN;
            else
                eopLatch <= 1'b0;
        end
    end

    always_comb begin
        HRQ              = (state != SI);
        DACK             = inXfer ? (4'b0001 << activeChannel) : 4'b0000;
        AEN              = inXfer;
        ADSTB            = (state == S1);
        loadAddr         = (state == S1);
        MEMR_N           = !(((state == S2) || (state == S3)) && chXfer == XFER_READ);
        IOR_N_OUT        = !(((state == S2) || (state == S3)) && chXfer == XFER_WRITE);
        IOW_N_OUT        = !((state == S3) && chXfer == XFER_READ);
        MEMW_N           = !((state == S3) && chXfer == XFER_WRITE);
        updateCurrentAddressReg   = (state == S4) && HLDA;
        updateCurrentWordCountReg = (state == S4) && HLDA;
        intEOP           = (state == S4) && HLDA && terminate;
        EOP_N_OUT        = !intEOP;
        // Held at 1 while reset is asserted regardless of HLDA.
        programCondition = (state == SI) && (!HLDA || !RESET_N);
    end

endmodule

// File: tb/tb_dma_timing_control.sv
// tb/tb_dma_timing_control.sv - randomized self-checking bench with transaction-level reference model
module tb_dma_timing_control;
    import dma_pkg::*;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       HLDA;
    logic       EOP_N_IN;
    logic       cmdDisable;
    logic       cmdRotate;
    logic [7:0] modeXfer;
    logic [7:0] modeSel;
    logic       tcIn;
    logic       HRQ;
    logic [3:0] DACK;
    logic       AEN, ADSTB, MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT, EOP_N_OUT;
    logic [1:0] activeChannel;
    logic       programCondition, loadAddr, updateCurrentAddressReg, updateCurrentWordCountReg, intEOP;

    int checks = 0;
    int errors = 0;
    int highest = 0;

    always #5 CLK = ~CLK;

    dma_timing_control dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .EOP_N_IN(EOP_N_IN),
        .cmdDisable(cmdDisable), .cmdRotate(cmdRotate), .modeXfer(modeXfer), .modeSel(modeSel),
        .tcIn(tcIn), .HRQ(HRQ), .DACK(DACK), .AEN(AEN), .ADSTB(ADSTB), .MEMR_N(MEMR_N),
        .MEMW_N(MEMW_N), .IOR_N_OUT(IOR_N_OUT), .IOW_N_OUT(IOW_N_OUT), .EOP_N_OUT(EOP_N_OUT),
        .activeChannel(activeChannel), .programCondition(programCondition), .loadAddr(loadAddr),
        .updateCurrentAddressReg(updateCurrentAddressReg),
        .updateCurrentWordCountReg(updateCurrentWordCountReg), .intEOP(intEOP)
    );

    logic [18:0] obs;
    assign obs = {HRQ, DACK, AEN, ADSTB, MEMR_N, MEMW_N, IOR_N_OUT, IOW_N_OUT, EOP_N_OUT,
                  activeChannel, programCondition, loadAddr, updateCurrentAddressReg,
                  updateCurrentWordCountReg, intEOP};

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Phase: 0 idle, 1 waiting for hold, 2..5 the four cycles of one transfer.
    function automatic logic [18:0] expv(input int ph, input int ch, input logic [1:0] xf,
                                         input bit term, input bit hlda);
        bit rd, wr, busy, src, dst, last;
        logic [3:0] dk;
        rd   = (xf == XFER_READ);
        wr   = (xf == XFER_WRITE);
        busy = (ph >= 2);
        src  = (ph == 3) || (ph == 4);
        dst  = (ph == 4);
        last = (ph == 5);
        dk   = busy ? 4'(1 << ch) : 4'h0;
        return {ph != 0, dk, busy, ph == 2, !(rd && src), !(wr && dst), !(wr && src),
                !(rd && dst), !(last && term), 2'(ch), (ph == 0) && !hlda, ph == 2,
                last, last, last && term};
    endfunction

    function automatic int pick(input logic [3:0] dq, input bit rot, input int hi);
        int base, res;
        bit found;
        base = rot ? hi : 0;
        res = 0;
        found = 0;
        for (int k = 0; k < 4; k++) begin
            if (!found && dq[(base + k) % 4]) begin
                res = (base + k) % 4;
                found = 1;
            end
        end
        return res;
    endfunction

    // One arbitration-to-idle session; tcAt/eopAt/dropAt/abortAt name the transfer (1-based) where each event hits.
    task automatic session(input logic [3:0] dq, input bit rot, input int d, input int tcAt,
                           input int eopAt, input int dropAt, input int abortAt);
        int ch, last;
        logic [1:0] md, xf;
        bit term;
        cmdRotate  = rot;
        cmdDisable = 1'b0;
        ch = pick(dq, rot, highest);
        md = modeSel[2*ch +: 2];
        xf = modeXfer[2*ch +: 2];
        if (md == MODE_SINGLE) last = 1;
        else begin
            last = tcAt;
            if (eopAt != 0 && eopAt < last) last = eopAt;
            if (md == MODE_DEMAND && dropAt != 0 && dropAt < last) last = dropAt;
        end
        term = (tcAt == last) || (eopAt == last);

        DREQ = dq;
        HLDA = 1'b0;
        tick();
        for (int k = 0; k < d; k++) begin
            #1 check_val("S0", obs, expv(1, ch, xf, 0, 0));
            if (k == d - 1) HLDA = 1'b1;
            tick();
        end
        for (int i = 1; i <= last; i++) begin
            #1 check_val("S1", obs, expv(2, ch, xf, 0, 1));
            tick();
            if (eopAt == i) EOP_N_IN = 1'b0;
            if (abortAt == i) HLDA = 1'b0;
            #1 check_val("S2", obs, expv(3, ch, xf, 0, 1));
            tick();
            EOP_N_IN = 1'b1;
            if (abortAt == i) begin
                #1 check_val("abort_si", obs, expv(0, ch, xf, 0, 0));
                DREQ = 4'h0;
                tick();
                #1 check_val("abort_idle", obs, expv(0, ch, xf, 0, 0));
                return;
            end
            if (md == MODE_DEMAND && dropAt == i) DREQ[ch] = 1'b0;
            #1 check_val("S3", obs, expv(4, ch, xf, 0, 1));
            tick();
            tcIn = (tcAt == i);
            #1 check_val("S4", obs, expv(5, ch, xf, (i == last) && term, 1));
            tick();
            tcIn = 1'b0;
        end
        highest = (ch + 1) % 4;
        #1 check_val("SI_gap", obs, expv(0, ch, xf, 0, 1));
        DREQ = 4'h0;
        HLDA = 1'b0;
        tick();
        #1 check_val("SI_idle", obs, expv(0, ch, xf, 0, 0));
    endtask

    initial begin
        RESET_N = 1'b0; DREQ = 4'h0; HLDA = 1'b0; EOP_N_IN = 1'b1; cmdDisable = 1'b0;
        cmdRotate = 1'b0; modeXfer = 8'h00; modeSel = 8'h00; tcIn = 1'b0;
        #1 check_val("reset", obs, expv(0, 0, XFER_VERIFY, 0, 0));
        tick();
        tick();
        RESET_N = 1'b1;
        tick();

        modeSel[2 +: 2] = MODE_SINGLE;  modeXfer[2 +: 2] = XFER_READ;
        session(4'b0110, 0, 2, 2, 0, 0, 0);
        session(4'b0110, 0, 2, 2, 0, 0, 0);

        modeSel[0 +: 2] = MODE_BLOCK;   modeXfer[0 +: 2] = XFER_WRITE;
        session(4'b0001, 0, 1, 3, 0, 0, 0);
        session(4'b0001, 0, 1, 3, 1, 0, 0);
        session(4'b0001, 0, 1, 3, 0, 0, 1);

        modeSel[0 +: 2] = MODE_DEMAND;  modeXfer[0 +: 2] = XFER_READ;
        session(4'b0001, 0, 1, 3, 0, 2, 0);

        cmdDisable = 1'b1;
        DREQ = 4'hF;
        for (int k = 0; k < 4; k++) begin
            tick();
            check_val("dis_hrq", {31'd0, HRQ}, 32'd0);
            check_val("dis_pc", {31'd0, programCondition}, 32'd1);
        end
        DREQ = 4'h0;
        cmdDisable = 1'b0;
        tick();

        for (int n = 0; n < 24; n++) begin
            for (int c = 0; c < 4; c++) begin
                modeSel[2*c +: 2]  = 2'($urandom_range(0, 2));
                modeXfer[2*c +: 2] = 2'($urandom_range(0, 2));
            end
            session(4'($urandom_range(1, 15)), bit'($urandom_range(0, 1)), $urandom_range(1, 3),
                    $urandom_range(1, 3),
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0,
                    ($urandom_range(0, 1) == 1) ? $urandom_range(1, 3) : 0,
                    ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0);
        end

        modeSel[4 +: 2] = MODE_SINGLE;  modeXfer[4 +: 2] = XFER_READ;
        cmdRotate = 1'b0;
        DREQ = 4'b0100;
        HLDA = 1'b0;
        tick();
        HLDA = 1'b1;
        tick();
        tick();
        tick();
        #1 check_val("pre_rst_S3", obs, expv(4, 2, XFER_READ, 0, 1));
        RESET_N = 1'b0;
        #1 check_val("mid_reset", obs, expv(0, 0, XFER_VERIFY, 0, 0));
        DREQ = 4'h0;
        HLDA = 1'b0;
        tick();
        RESET_N = 1'b1;
        highest = 0;
        tick();

        modeSel = {MODE_SINGLE, MODE_SINGLE, MODE_SINGLE, MODE_SINGLE};
        modeXfer = {XFER_READ, XFER_WRITE, XFER_VERIFY, XFER_READ};
        for (int n = 0; n < 5; n++) session(4'hF, 1, 1, 2, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
